pulse_level_stretcher: RTL and testbench

- Inverse of the front-panel edge detectors: turns single-cycle strobes (timer ticks, key events) into clean level windows that drive stove indicator LEDs, buzzer and heater-enable lines.
- Each accepted strobe gives a high window of HOLD_CYCLES, then a mandatory low gap of GAP_CYCLES, so every window shows a distinct rising edge to any downstream edge detector.
- Strobes that arrive while a window or gap is active are queued up to PEND_MAX. Further strobes are dropped and flagged.

---
 rtl/stove_pkg.sv | 18 +
 rtl/cycle_down_counter.sv | 27 ++
 rtl/pulse_level_stretcher.sv | 118 +++++++++++
 tb/tb_pulse_level_stretcher.sv | 139 +++++++++++++
 4 files changed

// File: rtl/stove_pkg.sv
// Shared types and constants for the front-panel pulse-to-level stretcher.
package stove_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_GAP_CYCLES  = 2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag; shared by the HOLD and GAP phases.
module cycle_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_comb o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_level_stretcher.sv
// Stretches single-cycle strobes into HOLD_CYCLES-high windows separated by
// GAP_CYCLES-low gaps, queueing up to PEND_MAX strobes that arrive mid-window.
module pulse_level_stretcher
  import stove_pkg::*;
#(
  parameter  int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter  int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter  int unsigned PEND_MAX    = 3,
  localparam int unsigned PW          = width_for(PEND_MAX)
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          pulse_in,
  output logic          level_out,
  output logic          busy,
  output logic          overflow,
  output logic [PW-1:0] pending_count
);

  localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = width_for(CMAX);
  // Counter is loaded with length-1 so the zero flag marks the last clock of a phase.
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_LIM = PW'(PEND_MAX);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_cnt_load;
  logic [CW-1:0]   w_cnt_val;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic            w_last_gap;
  logic            w_dequeue;
  logic            w_queue;
  logic [PW-1:0]   r_pending;
  logic            r_overflow;

  cycle_down_counter #(.WIDTH(CW)) u_cnt (
    .i_clk      (clk),
    .i_rst      (sync_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = HOLD_LD;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (pulse_in) begin
          w_next_state = HOLD;
          w_cnt_load   = 1'b1;
        end
      end
      HOLD: begin
        if (w_cnt_zero) begin
          w_next_state = GAP;
          w_cnt_load   = 1'b1;
          w_cnt_val    = GAP_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          if ((r_pending != '0) || pulse_in) begin
            w_next_state = HOLD;
            w_cnt_load   = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    level_out     = (r_state == HOLD);
    busy          = (r_state != IDLE);
    overflow      = r_overflow;
    pending_count = r_pending;
  end

  // Last-GAP strobes never queue: they either restart HOLD or cancel the dequeue.
  always_comb begin
    w_last_gap = (r_state == GAP) && w_cnt_zero;
    w_dequeue  = w_last_gap && (r_pending != '0);
    w_queue    = pulse_in && ((r_state == HOLD) || ((r_state == GAP) && !w_cnt_zero));
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_queue && (r_pending == PEND_LIM);
      if (w_dequeue) begin
        if (!pulse_in) r_pending <= r_pending - 1'b1;
      end else if (w_queue && (r_pending != PEND_LIM)) begin
        r_pending <= r_pending + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_level_stretcher.sv
// Directed bench for pulse_level_stretcher with default parameters.
module tb_pulse_level_stretcher;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic       pulse_in;
  logic       level_out;
  logic       busy;
  logic       overflow;
  logic [1:0] pending_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pulse_level_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_MAX    (3)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .pulse_in      (pulse_in),
    .level_out     (level_out),
    .busy          (busy),
    .overflow      (overflow),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".lvl"}, 32'(level_out), 32'd0);
    check({tag, ".bsy"}, 32'(busy), 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
    check({tag, ".pnd"}, 32'(pending_count), 32'd0);
  endtask

  // One character per cycle; entered just after a rising edge, cycle k's
  // strobe is driven at its start and outputs are sampled mid-cycle.
  task automatic run_vec(input string name, input string pul, input string lvl,
                         input string bsy, input string ovf, input string pnd);
    for (int k = 0; k < pul.len(); k++) begin
      #1;
      pulse_in = (pul[k] == "1");
      @(negedge clk);
      check($sformatf("%s.lvl[%0d]", name, k), 32'(level_out), 32'(lvl[k] == "1"));
      check($sformatf("%s.bsy[%0d]", name, k), 32'(busy), 32'(bsy[k] == "1"));
      check($sformatf("%s.ovf[%0d]", name, k), 32'(overflow), 32'(ovf[k] == "1"));
      check($sformatf("%s.pnd[%0d]", name, k), 32'(pending_count), 32'(int'(pnd[k]) - 48));
      @(posedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sync_reset = 1'b1;
    pulse_in   = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      pulse_in = ~pulse_in;
      @(negedge clk);
      check_idle($sformatf("reset[%0d]", i));
      @(posedge clk);
    end
    #1;
    sync_reset = 1'b0;
    pulse_in   = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
    @(posedge clk);

    run_vec("single",
            "1000000000",
            "0111100000",
            "0111111000",
            "0000000000",
            "0000000000");

    run_vec("two",
            "10100000000000",
            "01111001111000",
            "01111111111110",
            "00000000000000",
            "00011110000000");

    run_vec("burst",
            "1111100000000000000000000000",
            "0111100111100111100111100000",
            "0111111111111111111111111000",
            "0000010000000000000000000000",
            "0012333222222111111000000000");

    run_vec("lastgap",
            "1000001000000000",
            "0111100111100000",
            "0111111111111000",
            "0000000000000000",
            "0000000000000000");

    run_vec("rst_pre", "111", "011", "011", "000", "001");
    #1;
    sync_reset = 1'b1;
    pulse_in   = 1'b1;
    @(negedge clk);
    check("rst_mid.pnd", 32'(pending_count), 32'd2);
    check("rst_mid.lvl", 32'(level_out), 32'd1);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    pulse_in   = 1'b0;
    @(negedge clk);
    check_idle("rst_after");
    @(posedge clk);
    run_vec("rst_post",
            "00000000000000000000",
            "00000000000000000000",
            "00000000000000000000",
            "00000000000000000000",
            "00000000000000000000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
